// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and glitch counter constants for debounce_filter
package debounce_pkg;
   typedef logic [1:0] state_t;
   localparam state_t STABLE_LO = 2'd0;
   localparam state_t QUAL_HI   = 2'd1;
   localparam state_t STABLE_HI = 2'd2;
   localparam state_t QUAL_LO   = 2'd3;
   localparam int GLITCH_W = 8;
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser for one asynchronous level
// ports: clk clock, reset async active-low, d async input, q synchronised output
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] s_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) s_q <= '0;
      else s_q <= {s_q[SYNC_STAGES-2:0], d};
   assign q = s_q[SYNC_STAGES-1];
endmodule

// File: rtl/debounce_filter.sv
// debounce_filter: synchronises a bouncy level and qualifies it for STABLE_CYCLES samples
// ports: clk clock, reset async active-low, a_raw raw level, clean_out debounced level,
//        busy qualification in progress, glitch_cnt aborted qualifications (DEBOUNCE_GLITCH_CNT_EN)
module debounce_filter
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 16,
   parameter int STABLE_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic a_raw,
   output logic clean_out,
   output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);
   if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_cycles
      $error("debounce_filter: STABLE_CYCLES out of range");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("debounce_filter: SYNC_STAGES out of range");
   end
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   // the entry edge is the first qualifying sample, so the count starts at 1
   localparam logic [CNT_W-1:0] FIRST = CNT_W'(1);
   localparam bit ONE = STABLE_CYCLES == 1;
   logic sync_q;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .reset(reset),
      .d(a_raw),
      .q(sync_q)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         STABLE_LO: if (sync_q) begin
            state_d = ONE ? STABLE_HI : QUAL_HI;
            cnt_d   = ONE ? '0 : FIRST;
         end
         QUAL_HI: begin
            state_d = !sync_q ? STABLE_LO : cnt_q == LAST ? STABLE_HI : QUAL_HI;
            cnt_d   = !sync_q || cnt_q == LAST ? '0 : cnt_q + 1'b1;
         end
         STABLE_HI: if (!sync_q) begin
            state_d = ONE ? STABLE_LO : QUAL_LO;
            cnt_d   = ONE ? '0 : FIRST;
         end
         default: begin
            state_d = sync_q ? STABLE_HI : cnt_q == LAST ? STABLE_LO : QUAL_LO;
            cnt_d   = sync_q || cnt_q == LAST ? '0 : cnt_q + 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   // both outputs decode straight from the state register, so neither has a path from a_raw
   assign clean_out = state_q == STABLE_HI || state_q == QUAL_LO;
   assign busy      = state_q == QUAL_HI || state_q == QUAL_LO;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [GLITCH_W-1:0] glitch_q;
   logic abort;
   assign abort = (state_q == QUAL_HI && !sync_q) || (state_q == QUAL_LO && sync_q);
   always_ff @(posedge clk or negedge reset)
      if (!reset) glitch_q <= '0;
      else if (abort && glitch_q != GLITCH_MAX) glitch_q <= glitch_q + 1'b1;
   assign glitch_cnt = glitch_q;
`endif
endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: table, hand-sequence and random checks of debounce_filter against a run-length model
module tb_debounce_filter;
   localparam int SYNC = 2;
   logic clk = 0;
   logic reset = 0;
   logic a_raw = 0;
   logic c4, b4, c1, b1;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] g4, g1;
`endif
   debounce_filter #(.SYNC_STAGES(SYNC), .CNT_W(16), .STABLE_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .a_raw(a_raw), .clean_out(c4), .busy(b4)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      , .glitch_cnt(g4)
`endif
   );
   debounce_filter #(.SYNC_STAGES(SYNC), .CNT_W(16), .STABLE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .a_raw(a_raw), .clean_out(c1), .busy(b1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      , .glitch_cnt(g1)
`endif
   );
   // model: clean level plus length of the current run of samples disagreeing with it
   int need[2] = '{4, 1};
   int m_clean[2], m_run[2], m_gl[2];
   bit hist[SYNC];
   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_clean[d] = 0;
         m_run[d] = 0;
         m_gl[d] = 0;
      end
      for (int i = 0; i < SYNC; i++) hist[i] = 0;
   endfunction
   function automatic void model_edge(bit raw);
      int s;
      s = int'(hist[SYNC-1]);
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw;
      for (int d = 0; d < 2; d++) begin
         if (s != m_clean[d]) begin
            m_run[d]++;
            if (m_run[d] == need[d]) begin
               m_clean[d] = s;
               m_run[d] = 0;
            end
         end else begin
            if (m_run[d] > 0 && m_gl[d] < 255) m_gl[d]++;
            m_run[d] = 0;
         end
      end
   endfunction
   task automatic chk(string nm, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic check_all();
      chk("clean4", int'(c4), m_clean[0]);
      chk("busy4", int'(b4), int'(m_run[0] > 0));
      chk("clean1", int'(c1), m_clean[1]);
      chk("busy1", int'(b1), int'(m_run[1] > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("glitch4", int'(g4), m_gl[0]);
      chk("glitch1", int'(g1), m_gl[1]);
`endif
   endtask
   task automatic edge_chk(bit raw);
      @(posedge clk);
      #1;
      model_edge(raw);
      check_all();
   endtask
   task automatic step(bit raw);
      @(negedge clk);
      a_raw = raw;
      edge_chk(raw);
   endtask
   typedef struct {
      bit raw;
      bit clean;
      bit busy;
      bit clean1;
   } vec_t;
   vec_t tbl[8];
   int n;
   int g0;
   bit r;
   initial begin
      tbl[0] = '{1, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 0};
      tbl[2] = '{1, 0, 1, 1};
      tbl[3] = '{1, 0, 1, 1};
      tbl[4] = '{1, 0, 1, 1};
      tbl[5] = '{1, 1, 0, 1};
      tbl[6] = '{1, 1, 0, 1};
      tbl[7] = '{1, 1, 0, 1};
      model_reset();
      #1;
      chk("rst_clean4", int'(c4), 0);
      chk("rst_busy4", int'(b4), 0);
      chk("rst_clean1", int'(c1), 0);
      @(negedge clk);
      reset = 1;
      for (int i = 0; i < 3; i++) step(0);
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].raw);
         chk("tbl_clean", int'(c4), int'(tbl[i].clean));
         chk("tbl_busy", int'(b4), int'(tbl[i].busy));
         chk("tbl_clean1", int'(c1), int'(tbl[i].clean1));
      end
      n = 0;
      do begin
         step(0);
         n++;
      end while (c4 && n < 20);
      chk("fall_latency", n, 6);
      for (int i = 0; i < 6; i++) step(0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      g0 = int'(g4);
`endif
      step(1);
      step(0);
      step(1);
      step(0);
      n = 0;
      do begin
         step(1);
         n++;
         if (n < 6) chk("bounce_hold", int'(c4), 0);
      end while (!c4 && n < 20);
      chk("bounce_latency", n, 6);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("bounce_glitches", int'(g4) - g0, 2);
`endif
      for (int i = 0; i < 8; i++) step(0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      g0 = int'(g4);
`endif
      for (int i = 0; i < 3; i++) step(1);
      for (int i = 0; i < 8; i++) begin
         step(0);
         chk("pulse_low", int'(c4), 0);
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("pulse_glitch", int'(g4) - g0, 1);
`endif
      for (int i = 0; i < 4; i++) step(1);
      chk("qual_busy", int'(b4), 1);
      @(negedge clk);
      reset = 0;
      model_reset();
      #1;
      chk("async_clean", int'(c4), 0);
      chk("async_busy", int'(b4), 0);
      chk("async_clean1", int'(c1), 0);
      @(negedge clk);
      reset = 1;
      a_raw = 1;
      edge_chk(1);
      n = 1;
      while (!c4 && n < 20) begin
         step(1);
         n++;
      end
      chk("post_reset_latency", n, 6);
      r = 0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) r = !r;
         step(r);
      end
      for (int i = 0; i < 10; i++) step(0);
      for (int i = 0; i < 300; i++) begin
         step(1);
         step(0);
      end
      chk("sat_clean", int'(c4), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("sat_glitch", int'(g4), 255);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
